// File: rtl/comparator_pipe_if.sv
//------------------------------------------------------------------------------
// Module      : comparator_pipe_if
// Description : Sample/result bundle for comparator_pipe (master drives samples).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface comparator_pipe_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
);
    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             clear;
    logic             out_valid;
    logic             y;
    logic             z;
    logic             eq;
    logic [WIDTH-1:0] max_val;
    logic [CNT_W-1:0] gt_run;
    logic             gt_sat;

    modport master (
        output in_valid, a, b, clear,
        input  out_valid, y, z, eq, max_val, gt_run, gt_sat
    );

    modport slave (
        input  in_valid, a, b, clear,
        output out_valid, y, z, eq, max_val, gt_run, gt_sat
    );
endinterface

`default_nettype wire

// File: rtl/comparator_pipe.sv
//------------------------------------------------------------------------------
// Module      : comparator_pipe
// Description : Registered magnitude comparator with running max and a>b run count.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module comparator_pipe #(
    parameter int WIDTH  = 8,
    parameter int SIGNED = 0,
    parameter int CNT_W  = 4
) (
    input  wire logic        clk,
    input  wire logic        reset,
    comparator_pipe_if.slave bus
);

    localparam logic [WIDTH-1:0] c_one     = WIDTH'(1);
    localparam logic [WIDTH-1:0] c_max_rst = (SIGNED != 0) ? (c_one << (WIDTH - 1)) : '0;
    localparam logic [CNT_W-1:0] c_sat     = '1;

    logic             r_out_valid;
    logic             r_y;
    logic             r_z;
    logic             r_eq;
    logic [WIDTH-1:0] r_max_val;
    logic [CNT_W-1:0] r_gt_run;
    logic             r_gt_sat;

    logic             w_a_gt_b;
    logic             w_a_eq_b;
    logic             w_a_gt_max;
    logic [WIDTH-1:0] w_max_base;
    logic [CNT_W-1:0] w_run_base;
    logic [WIDTH-1:0] w_max_next;
    logic [CNT_W-1:0] w_run_next;

    assign w_a_eq_b = (bus.a == bus.b);

    generate
        if (SIGNED != 0) begin : g_signed
            assign w_a_gt_b   = $signed(bus.a) > $signed(bus.b);
            assign w_a_gt_max = $signed(bus.a) > $signed(w_max_base);
        end else begin : g_unsigned
            assign w_a_gt_b   = bus.a > bus.b;
            assign w_a_gt_max = bus.a > w_max_base;
        end
    endgenerate

    // A clear on the accepting edge makes the sample start from the cleared state.
    always_comb begin
        w_max_base = bus.clear ? c_max_rst : r_max_val;
        w_run_base = bus.clear ? '0 : r_gt_run;
        w_max_next = r_max_val;
        w_run_next = r_gt_run;
        if (bus.in_valid) begin
            if (w_a_gt_b) begin
                w_run_next = (w_run_base == c_sat) ? c_sat : w_run_base + CNT_W'(1);
            end else begin
                w_run_next = '0;
            end
            w_max_next = w_a_gt_max ? bus.a : w_max_base;
        end else if (bus.clear) begin
            w_run_next = '0;
            w_max_next = c_max_rst;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_y         <= 1'b0;
            r_z         <= 1'b0;
            r_eq        <= 1'b0;
            r_max_val   <= c_max_rst;
            r_gt_run    <= '0;
            r_gt_sat    <= 1'b0;
        end else begin
            r_out_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_y  <= w_a_gt_b | w_a_eq_b;
                r_z  <= ~w_a_gt_b;
                r_eq <= w_a_eq_b;
            end
            r_max_val <= w_max_next;
            r_gt_run  <= w_run_next;
            r_gt_sat  <= (w_run_next == c_sat);
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.y         = r_y;
    assign bus.z         = r_z;
    assign bus.eq        = r_eq;
    assign bus.max_val   = r_max_val;
    assign bus.gt_run    = r_gt_run;
    assign bus.gt_sat    = r_gt_sat;

endmodule

`default_nettype wire

// File: tb/tb_comparator_pipe.sv
//------------------------------------------------------------------------------
// Module      : tb_comparator_pipe
// Description : Self-checking bench; unsigned and signed instances share stimulus.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_comparator_pipe;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    comparator_pipe_if #(.WIDTH(8), .CNT_W(4)) if0 ();
    comparator_pipe_if #(.WIDTH(8), .CNT_W(4)) if1 ();

    comparator_pipe #(.WIDTH(8), .SIGNED(0), .CNT_W(4)) u_dut_u (
        .clk(clk), .reset(reset), .bus(if0.slave));
    comparator_pipe #(.WIDTH(8), .SIGNED(1), .CNT_W(4)) u_dut_s (
        .clk(clk), .reset(reset), .bus(if1.slave));

    // Observed outputs packed as {out_valid, y, z, eq, max_val, gt_run, gt_sat}
    logic [16:0] obs [2];
    assign obs[0] = {if0.out_valid, if0.y, if0.z, if0.eq, if0.max_val, if0.gt_run, if0.gt_sat};
    assign obs[1] = {if1.out_valid, if1.y, if1.z, if1.eq, if1.max_val, if1.gt_run, if1.gt_sat};

    // Reference model: integer values, index 0 = unsigned, 1 = signed
    logic m_ov [2];
    logic m_y  [2];
    logic m_z  [2];
    logic m_eq [2];
    int   m_max [2];
    int   m_run [2];

    function automatic int val(int k, logic [7:0] x);
        if (k == 1 && x >= 8'd128) return int'(x) - 256;
        return int'(x);
    endfunction

    function automatic logic [16:0] exp_pack(int k);
        logic [7:0] mx;
        logic [3:0] rn;
        int t;
        t  = m_max[k];
        mx = t[7:0];
        t  = m_run[k];
        rn = t[3:0];
        return {m_ov[k], m_y[k], m_z[k], m_eq[k], mx, rn, (m_run[k] == 15)};
    endfunction

    task automatic model_edge(logic rst, logic iv, logic [7:0] a, logic [7:0] b, logic clr);
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_ov[k] = 0; m_y[k] = 0; m_z[k] = 0; m_eq[k] = 0;
                m_run[k] = 0; m_max[k] = (k == 1) ? -128 : 0;
            end else begin
                int va, vb;
                va = val(k, a);
                vb = val(k, b);
                m_ov[k] = iv;
                if (clr) begin
                    m_run[k] = 0;
                    m_max[k] = (k == 1) ? -128 : 0;
                end
                if (iv) begin
                    m_y[k]  = (va >= vb);
                    m_z[k]  = (va <= vb);
                    m_eq[k] = (va == vb);
                    m_run[k] = (va > vb) ? ((m_run[k] < 15) ? m_run[k] + 1 : 15) : 0;
                    if (va > m_max[k]) m_max[k] = va;
                end
            end
        end
    endtask

    task automatic step(logic rst, logic iv, logic [7:0] a, logic [7:0] b, logic clr);
        reset = rst;
        if0.in_valid = iv; if0.a = a; if0.b = b; if0.clear = clr;
        if1.in_valid = iv; if1.a = a; if1.b = b; if1.clear = clr;
        @(posedge clk);
        model_edge(rst, iv, a, b, clr);
        #1;
    endtask

    task automatic test_reset();
        step(1'b1, 1'b1, 8'h55, 8'h11, 1'b1);
        step(1'b1, 1'b1, 8'hF0, 8'h01, 1'b0);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (obs[k] !== exp_pack(k)) begin
                failures++;
                $display("FAIL reset[%0d]: got %h want %h", k, obs[k], exp_pack(k));
            end
        end
        checks++;
        if (if1.max_val !== 8'h80 || if0.max_val !== 8'h00) begin
            failures++;
            $display("FAIL reset_max: got u=%h s=%h want u=00 s=80", if0.max_val, if1.max_val);
        end
    endtask

    task automatic test_basic_codes();
        logic [7:0] av [3] = '{8'd5, 8'd3, 8'd4};
        logic [7:0] bv [3] = '{8'd3, 8'd5, 8'd4};
        logic [3:0] want [3] = '{4'b1100, 4'b1010, 4'b1111};
        step(1'b1, 1'b0, 8'h0, 8'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, av[i], bv[i], 1'b0);
            checks++;
            if ({if0.out_valid, if0.y, if0.z, if0.eq} !== want[i]) begin
                failures++;
                $display("FAIL code%0d: got %b want %b", i,
                         {if0.out_valid, if0.y, if0.z, if0.eq}, want[i]);
            end
        end
        // idle cycle: out_valid drops, code holds
        step(1'b0, 1'b0, 8'd9, 8'd1, 1'b0);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (obs[k] !== exp_pack(k)) begin
                failures++;
                $display("FAIL idle_hold[%0d]: got %h want %h", k, obs[k], exp_pack(k));
            end
        end
    endtask

    task automatic test_signedness();
        step(1'b0, 1'b1, 8'h80, 8'h7F, 1'b0);
        checks++;
        if ({if0.y, if0.z, if1.y, if1.z} !== 4'b1001) begin
            failures++;
            $display("FAIL signedness: got u=%b%b s=%b%b want u=10 s=01",
                     if0.y, if0.z, if1.y, if1.z);
        end
    endtask

    task automatic test_saturation();
        step(1'b1, 1'b0, 8'h0, 8'h0, 1'b0);
        for (int i = 1; i <= 20; i++) begin
            step(1'b0, 1'b1, 8'($urandom_range(100, 120)), 8'($urandom_range(0, 50)), 1'b0);
            repeat ($urandom_range(0, 2)) step(1'b0, 1'b0, 8'($urandom), 8'($urandom), 1'b0);
            checks++;
            if (if0.gt_run !== 4'((i < 15) ? i : 15) || if0.gt_sat !== (i >= 15) ||
                obs[1] !== exp_pack(1)) begin
                failures++;
                $display("FAIL sat_run%0d: got run=%0d sat=%b s=%h want run=%0d sat=%b s=%h",
                         i, if0.gt_run, if0.gt_sat, obs[1], (i < 15) ? i : 15, (i >= 15),
                         exp_pack(1));
            end
        end
        step(1'b0, 1'b1, 8'd77, 8'd77, 1'b0);
        checks++;
        if (if0.gt_run !== 4'd0 || if0.gt_sat !== 1'b0) begin
            failures++;
            $display("FAIL sat_break: got run=%0d sat=%b want run=0 sat=0", if0.gt_run, if0.gt_sat);
        end
    endtask

    task automatic test_max_clear();
        logic [7:0] av [4]   = '{8'd3, 8'd9, 8'd2, 8'd1};
        logic [7:0] want [4] = '{8'd3, 8'd9, 8'd9, 8'd1};
        step(1'b1, 1'b0, 8'h0, 8'h0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, av[i], 8'd0, i == 3);
            checks++;
            if (if0.max_val !== want[i] || if1.max_val !== want[i]) begin
                failures++;
                $display("FAIL max%0d: got u=%0d s=%0d want %0d", i, if0.max_val, if1.max_val, want[i]);
            end
        end
        checks++;
        if (if0.gt_run !== 4'd1) begin
            failures++;
            $display("FAIL clear_iv_run: got %0d want 1", if0.gt_run);
        end
        step(1'b0, 1'b0, 8'd50, 8'd0, 1'b1);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (obs[k] !== exp_pack(k)) begin
                failures++;
                $display("FAIL clear_only[%0d]: got %h want %h", k, obs[k], exp_pack(k));
            end
        end
    endtask

    task automatic test_mid_reset();
        step(1'b1, 1'b0, 8'h0, 8'h0, 1'b0);
        step(1'b0, 1'b1, 8'd9, 8'd0, 1'b0);
        repeat (5) step(1'b0, 1'b1, 8'd5, 8'd1, 1'b0);
        checks++;
        if (if1.gt_run !== 4'd6 || if1.max_val !== 8'd9) begin
            failures++;
            $display("FAIL pre_reset: got run=%0d max=%0d want run=6 max=9", if1.gt_run, if1.max_val);
        end
        step(1'b1, 1'b1, 8'd20, 8'd1, 1'b0);
        checks++;
        if (obs[1] !== {4'b0000, 8'h80, 4'd0, 1'b0}) begin
            failures++;
            $display("FAIL mid_reset: got %h want %h", obs[1], {4'b0000, 8'h80, 4'd0, 1'b0});
        end
        step(1'b0, 1'b1, 8'd2, 8'd1, 1'b0);
        checks++;
        if (if1.gt_run !== 4'd1 || if1.max_val !== 8'd2) begin
            failures++;
            $display("FAIL fresh_run: got run=%0d max=%0d want run=1 max=2", if1.gt_run, if1.max_val);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            logic [7:0] a, b;
            a = 8'($urandom);
            b = ($urandom_range(0, 3) == 0) ? a : 8'($urandom);
            step($urandom_range(0, 39) == 0, $urandom_range(0, 2) != 0, a, b,
                 $urandom_range(0, 7) == 0);
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs[k] !== exp_pack(k)) begin
                    failures++;
                    $display("FAIL random%0d[%0d]: got %h want %h", i, k, obs[k], exp_pack(k));
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        if0.in_valid = 1'b0; if0.a = '0; if0.b = '0; if0.clear = 1'b0;
        if1.in_valid = 1'b0; if1.a = '0; if1.b = '0; if1.clear = 1'b0;
        test_reset();
        test_basic_codes();
        test_signedness();
        test_saturation();
        test_max_clear();
        test_mid_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
